// File: rtl/sample_path_pkg.sv
// Shared types and defaults for the sample RAM read path.
// Used by the reader top level and its output FIFO.
package sample_path_pkg;

    localparam int SAMPLE_ADDR_W     = 9;
    localparam int SAMPLE_DATA_W     = 8;
    localparam int SAMPLE_RD_LAT     = 2;
    localparam int SAMPLE_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO carrying {sop, eop, data} beats to the stream port.
// Power-of-two depth; clear empties it in one cycle.
module sample_fifo
    import sample_path_pkg::*;
#(
    parameter int WIDTH = SAMPLE_DATA_W + 2,
    parameter int DEPTH = SAMPLE_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when a pop frees the slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && !clear &&
                     ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign valid    = (count != '0);

endmodule

// File: rtl/sample_reader.sv
// Fetches a block of samples from the sample RAM read port and
// emits them as a sop/eop framed valid/ready stream.
module sample_reader
    import sample_path_pkg::*;
#(
    parameter int ADDR_W     = SAMPLE_ADDR_W,
    parameter int DATA_W     = SAMPLE_DATA_W,
    parameter int RD_LAT     = SAMPLE_RD_LAT,
    parameter int FIFO_DEPTH = SAMPLE_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int FL_W  = $clog2(RD_LAT + 1);
    localparam int ENT_W = DATA_W + 2;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_q;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_sop;
    logic [RD_LAT-1:0] pipe_eop;
    logic [FL_W-1:0]   flush_cnt;

    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;
    logic              room;
    logic              issue;
    logic              first_rd;
    logic              last_rd;
    logic              drained;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic              fifo_valid;
    logic [ENT_W-1:0]  fifo_din;
    logic [ENT_W-1:0]  fifo_dout;

    // Reads in flight already own a FIFO slot, so the FIFO cannot overflow.
    always_comb begin
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < RD_LAT; i++)
            occupancy = occupancy + OCC_W'(pipe_vld[i]);
    end

    assign room     = occupancy < OCC_W'(FIFO_DEPTH);
    assign issue    = (state == READ) && room;
    assign first_rd = (rem_q == len_q);
    assign last_rd  = (rem_q == LEN_W'(1));

    assign fifo_clear = (state == FLUSH) ||
                        (abort && (state != IDLE));
    assign fifo_push  = pipe_vld[RD_LAT-1] && !fifo_clear;
    assign fifo_din   = {pipe_sop[RD_LAT-1],
                         pipe_eop[RD_LAT-1],
                         avm_readdata};
    assign fifo_pop   = st_valid && st_ready;

    assign drained = !(|pipe_vld) &&
                     ((fifo_count == '0) ||
                      ((fifo_count == CNT_W'(1)) && fifo_pop));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (length == '0) ? DONE : READ;
            end
            READ: begin
                if (issue && last_rd)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (drained)
                    state_nx = DONE;
            end
            FLUSH: begin
                if (flush_cnt == FL_W'(RD_LAT - 1))
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && (state != IDLE))
            state_nx = FLUSH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            pipe_vld  <= '0;
            pipe_sop  <= '0;
            pipe_eop  <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;

            if ((state == IDLE) && start) begin
                addr_q <= base_addr;
                len_q  <= length;
                rem_q  <= length;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - LEN_W'(1);
            end

            // Frame tags ride alongside each read until its data returns.
            pipe_vld[0] <= issue;
            pipe_sop[0] <= issue && first_rd;
            pipe_eop[0] <= issue && last_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_sop[i] <= pipe_sop[i-1];
                pipe_eop[i] <= pipe_eop[i-1];
            end

            if ((state == FLUSH) && !abort)
                flush_cnt <= flush_cnt + FL_W'(1);
            else
                flush_cnt <= '0;
        end
    end

    sample_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .valid     (fifo_valid)
    );

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign avm_read       = issue;
    assign avm_chipselect = issue;
    assign avm_address    = addr_q;

    assign st_valid = fifo_valid;
    assign st_data  = st_valid ? fifo_dout[DATA_W-1:0] : '0;
    assign st_sop   = st_valid && fifo_dout[DATA_W+1];
    assign st_eop   = st_valid && fifo_dout[DATA_W];

endmodule

// File: tb/tb_sample_reader.sv
// Scoreboard bench for sample_reader with a fixed-latency RAM model.
module tb_sample_reader;
    import sample_path_pkg::*;

    localparam int AW    = SAMPLE_ADDR_W;
    localparam int DW    = SAMPLE_DATA_W;
    localparam int LAT   = SAMPLE_RD_LAT;
    localparam int DEPTH = SAMPLE_FIFO_DEPTH;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_read;
    logic [DW-1:0] avm_readdata;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          st_ready;
    logic          st_sop;
    logic          st_eop;

    sample_reader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_sop         (st_sop),
        .st_eop         (st_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    logic [DW-1:0] ram_pipe [LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= avm_read ? ram_val(avm_address) : '0;
        for (int i = 1; i < LAT; i++)
            ram_pipe[i] <= ram_pipe[i-1];
    end
    assign avm_readdata = ram_pipe[LAT-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [AW-1:0] addr_q [$];
    logic [DW+1:0] beat_q [$];
    int            occ;
    bit            stalled;
    bit            done_due;
    logic [DW+1:0] held;
    int            cyc, first_rd, last_rd, first_bt, last_bt;
    int            done_c, done_n, n_beats, stalls;

    task automatic sb_clear();
        addr_q.delete();
        beat_q.delete();
        occ      = 0;
        stalled  = 0;
        done_due = 0;
    endtask

    task automatic monitor();
        logic          exp_rd;
        logic [DW+1:0] exp_bt;
        if (reset)
            return;
        exp_rd = (addr_q.size() != 0) && (occ < DEPTH);
        chk("avm_read", avm_read, exp_rd);
        chk("avm_cs", avm_chipselect, exp_rd);
        if (addr_q.size() != 0 && occ >= DEPTH)
            stalls++;
        if (exp_rd && avm_read) begin
            chk("avm_addr", avm_address, addr_q.pop_front());
            occ++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (done_due)
            chk("done_after_eop", done, 1);
        done_due = 0;
        if (stalled) begin
            chk("hold_valid", st_valid, 1);
            chk("hold_beat", {st_sop, st_eop, st_data}, held);
        end
        if (st_valid && st_ready) begin
            if (beat_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                exp_bt = beat_q.pop_front();
                chk("beat", {st_sop, st_eop, st_data}, exp_bt);
                done_due = exp_bt[DW];
            end
            occ--;
            n_beats++;
            if (first_bt < 0) first_bt = cyc;
            last_bt = cyc;
        end
        if (done) begin
            if (done_c < 0) done_c = cyc;
            done_n++;
        end
        stalled = st_valid && !st_ready;
        held    = {st_sop, st_eop, st_data};
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_block(input logic [AW-1:0] b, input int len,
                               input bit ab);
        logic [AW-1:0] a;
        start     = 1'b1;
        abort     = ab;
        base_addr = b;
        length    = (AW+1)'(len);
        st_ready  = 1'b0;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < len; i++) begin
            a = AW'(int'(b) + i);
            addr_q.push_back(a);
            beat_q.push_back({i == 0, i == len - 1, ram_val(a)});
        end
        cyc = 0; first_rd = -1; last_rd = -1; first_bt = -1;
        last_bt = -1; done_c = -1; done_n = 0; n_beats = 0; stalls = 0;
    endtask

    task automatic wait_idle(input int mode, input int budget);
        int n;
        n = 0;
        do begin
            case (mode)
                0:       st_ready = 1'b1;
                1:       st_ready = (cyc % 3 == 0);
                default: st_ready = 1'b0;
            endcase
            cycle();
            n++;
        end while (busy && n < budget);
        chk("idle_in_budget", busy, 0);
    endtask

    task automatic run_block(input logic [AW-1:0] b, input int len,
                             input int mode, input bit ab);
        start_block(b, len, ab);
        wait_idle(mode, 4 * len + 64);
        chk("beats_left", beat_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        chk("n_beats", n_beats, len);
        chk("done_pulses", done_n, 1);
    endtask

    task automatic basic_test();
        run_block(9'h010, 8, 0, 0);
        chk("first_rd", first_rd, 0);
        chk("last_rd", last_rd, 7);
        chk("first_beat", first_bt, LAT + 1);
        chk("last_beat", last_bt, LAT + 8);
        chk("done_cycle", done_c, LAT + 9);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_read"}, avm_read, 0);
        chk({tag, "_cs"}, avm_chipselect, 0);
        chk({tag, "_addr"}, avm_address, 0);
        chk({tag, "_valid"}, st_valid, 0);
        chk({tag, "_data"}, st_data, 0);
        chk({tag, "_sop"}, st_sop, 0);
        chk({tag, "_eop"}, st_eop, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; st_ready = 1'b0;
        base_addr = '0; length = '0; cyc = 0;
        sb_clear();
        #1 reset = 1'b1;
        #2 check_quiet("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        basic_test();
        run_block(9'h1FE, 4, 0, 0);
        run_block(9'h080, 16, 1, 0);
        chk("stall_seen", stalls != 0, 1);
        run_block(9'h055, 0, 0, 0);
        chk("len0_done", done_c, 0);
        chk("len0_no_read", first_rd, -1);
        run_block(9'h123, 1, 0, 1);

        // abort during the third READ cycle with the sink stalled
        start_block(9'h040, 64, 0);
        cycle();
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        sb_clear();
        chk("abort_read", avm_read, 0);
        chk("abort_valid", st_valid, 0);
        chk("abort_done_early", done, 0);
        for (int k = 1; k < LAT; k++) begin
            cycle();
            chk("flush_done_early", done, 0);
        end
        cycle();
        chk("flush_done", done, 1);
        cycle();
        chk("flush_idle", busy, 0);
        run_block(9'h000, 2, 0, 0);

        run_block(9'h0C3, 512, 0, 0);

        start_block(9'h100, 32, 0);
        st_ready = 1'b1;
        for (int k = 0; k < 5; k++)
            cycle();
        #2 reset = 1'b1;
        #1 check_quiet("async_rst");
        sb_clear();
        cycle();
        cycle();
        reset = 1'b0;
        basic_test();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
